// File: rtl/frame_buffer.sv
// Double-buffered 32x16 RGB pixel store: producer fills the back bank, panel scan reads the front bank,
// and the banks swap only on frame_done. Optional build macro CLEAR_ON_SWAP_EN zeroes the back bank after each swap.
module frame_buffer #(
  parameter int COL_W   = 5,
  parameter int ROW_W   = 3,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_x,
  input  logic [ROW_W:0]     wr_y,
  input  logic [COLOR_W-1:0] wr_rgb,
  input  logic               swap_req,
  input  logic               frame_done,
  input  logic [COL_W-1:0]   rd_col,
  input  logic [ROW_W-1:0]   rd_row,
  output logic [COLOR_W-1:0] LED_Top,
  output logic [COLOR_W-1:0] LED_Bottom,
  output logic               busy,
  output logic               swap_done,
  output logic               front_bank
);

  localparam int ADDR_W = COL_W + ROW_W;
  localparam int DEPTH  = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_CLEAR} state_t;

`ifdef CLEAR_ON_SWAP_EN
  localparam state_t RESET_STATE = S_CLEAR;
  localparam state_t AFTER_SWAP  = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
  localparam state_t AFTER_SWAP  = S_IDLE;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic               r_front_bank;
  logic               r_swap_done;
  logic [COLOR_W-1:0] r_led_top;
  logic [COLOR_W-1:0] r_led_bot;
  logic               w_busy;
  logic               w_clearing;
  logic               w_swap_edge;
  logic               w_clr_all;
  logic               w_clr_last;
  logic [ADDR_W-1:0]  w_clr_addr;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_wr_ok;
  logic [COLOR_W-1:0] w_rd_data [4];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (swap_req)   w_state_next = S_PENDING;
      S_PENDING: if (frame_done) w_state_next = AFTER_SWAP;
      S_CLEAR:   if (w_clr_last) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_clearing  = (r_state == S_CLEAR);
    w_swap_edge = (r_state == S_PENDING) && frame_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_front_bank <= 1'b0;
      r_swap_done  <= 1'b0;
    end else begin
      r_swap_done <= w_swap_edge;
      if (w_swap_edge) r_front_bank <= ~r_front_bank;
    end
  end

`ifdef CLEAR_ON_SWAP_EN
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_clr_all;

  // The post-reset pass wipes all four arrays; post-swap passes touch only the new back bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr <= '0;
      r_clr_all  <= 1'b1;
    end else begin
      if (w_clearing)  r_clr_addr <= r_clr_addr + ADDR_W'(1);
      if (w_swap_edge) r_clr_all  <= 1'b0;
    end
  end

  assign w_clr_addr = r_clr_addr;
  assign w_clr_all  = r_clr_all;
  assign w_clr_last = (r_clr_addr == '1);
`else
  assign w_clr_addr = '0;
  assign w_clr_all  = 1'b0;
  assign w_clr_last = 1'b1;
`endif

  assign w_wr_addr = {wr_y[ROW_W-1:0], wr_x};
  assign w_rd_addr = {rd_row, rd_col};
  assign w_wr_ok   = wr_en && !w_busy;

  // Array index g: bit 1 = bank, bit 0 = half (0 top, 1 bottom).
  for (genvar g = 0; g < 4; g++) begin : g_mem
    localparam logic BANK = 1'((g >> 1) & 1);
    localparam logic HALF = 1'(g & 1);

    logic [COLOR_W-1:0] r_mem [DEPTH];
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [COLOR_W-1:0] w_data;

    assign w_we   = w_clearing ? (w_clr_all || (r_front_bank != BANK))
                               : (w_wr_ok && (r_front_bank != BANK) && (wr_y[ROW_W] == HALF));
    assign w_addr = w_clearing ? w_clr_addr : w_wr_addr;
    assign w_data = w_clearing ? '0 : wr_rgb;

    // NOTE: storage arrays carry no reset so they map onto RAM primitives.
    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_addr] <= w_data;
    end

    assign w_rd_data[g] = r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_top <= '0;
      r_led_bot <= '0;
    end else begin
      r_led_top <= w_rd_data[{r_front_bank, 1'b0}];
      r_led_bot <= w_rd_data[{r_front_bank, 1'b1}];
    end
  end

  assign LED_Top    = r_led_top;
  assign LED_Bottom = r_led_bot;
  assign busy       = w_busy;
  assign swap_done  = r_swap_done;
  assign front_bank = r_front_bank;

endmodule

// File: tb/tb_frame_buffer.sv
// Randomised bench for frame_buffer against a pixel-grid model of both banks (rows 0..15, cols 0..31).
// Build with CLEAR_ON_SWAP_EN defined to exercise the clearing variant.
`timescale 1ns/1ps
module tb_frame_buffer;
  localparam int COL_W = 5, ROW_W = 3, COLOR_W = 3;
  localparam int NCOL = 32, NROW = 16, NADDR = 256;
  localparam int MAX_CYCLES = 60000;
`ifdef CLEAR_ON_SWAP_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [COL_W-1:0] wr_x = '0;
  logic [ROW_W:0] wr_y = '0;
  logic [COLOR_W-1:0] wr_rgb = '0;
  logic swap_req = 1'b0, frame_done = 1'b0;
  logic [COL_W-1:0] rd_col = '0;
  logic [ROW_W-1:0] rd_row = '0;
  logic [COLOR_W-1:0] LED_Top, LED_Bottom;
  logic busy, swap_done, front_bank;

  always #5 clk = ~clk;

  frame_buffer #(.COL_W(COL_W), .ROW_W(ROW_W), .COLOR_W(COLOR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .frame_done(frame_done), .rd_col(rd_col), .rd_row(rd_row),
    .LED_Top(LED_Top), .LED_Bottom(LED_Bottom), .busy(busy), .swap_done(swap_done),
    .front_bank(front_bank)
  );

  int errors = 0, checks = 0, cycles = 0;

  // Reference model: two banks of a 16x32 pixel grid plus known-flags for undefined pixels.
  logic [COLOR_W-1:0] m_mem [2][NROW][NCOL];
  bit m_known [2][NROW][NCOL];
  bit m_front = 0, m_pending = 0, m_skip = 0;
  int m_clr_cnt = 0;
  logic [COLOR_W-1:0] e_top, e_bot;
  bit e_top_known = 0, e_bot_known = 0, e_swap_done = 0;

  function automatic bit m_busy();
    return m_pending || (m_clr_cnt > 0);
  endfunction

  task automatic zero_bank(input bit b);
    for (int y = 0; y < NROW; y++)
      for (int x = 0; x < NCOL; x++) begin
        m_mem[b][y][x] = '0;
        m_known[b][y][x] = 1'b1;
      end
  endtask

  // Advance one clock: predict the edge from the current inputs, then sample #1 after it.
  task automatic cycle();
    logic [COLOR_W-1:0] nt, nb;
    bit kt, kb, busy_pre;
    int rr;
    rr = int'(rd_row);
    nt = m_mem[m_front][rr][rd_col];
    nb = m_mem[m_front][rr + 8][rd_col];
    kt = m_known[m_front][rr][rd_col] && !m_skip;
    kb = m_known[m_front][rr + 8][rd_col] && !m_skip;
    busy_pre = m_busy();
    if (reset) begin
      nt = '0; nb = '0; kt = 1; kb = 1;
      m_front = 0; m_pending = 0; e_swap_done = 0;
      if (CLR) begin
        m_clr_cnt = NADDR; m_skip = 1;
        zero_bank(0); zero_bank(1);
      end
    end else begin
      e_swap_done = 0;
      if (m_clr_cnt > 0) begin
        m_clr_cnt--;
        if (m_clr_cnt == 0) m_skip = 0;
      end
      if (wr_en && !busy_pre) begin
        m_mem[!m_front][wr_y][wr_x] = wr_rgb;
        m_known[!m_front][wr_y][wr_x] = 1'b1;
      end
      if (m_pending && frame_done) begin
        m_pending = 0; m_front = !m_front; e_swap_done = 1;
        if (CLR) begin
          m_clr_cnt = NADDR;
          zero_bank(!m_front);
        end
      end else if (!busy_pre && swap_req) begin
        m_pending = 1;
      end
    end
    @(posedge clk); #1;
    e_top = nt; e_bot = nb; e_top_known = kt; e_bot_known = kb;
    cycles++;
    if (cycles > MAX_CYCLES) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cycles, MAX_CYCLES);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; swap_req = 0; frame_done = 0;
  endtask

  task automatic wait_idle();
    idle_inputs();
    for (int i = 0; i < 600 && m_busy(); i++) cycle();
  endtask

  task automatic write_px(input int x, input int y, input int rgb);
    wr_en = 1; wr_x = COL_W'(x); wr_y = (ROW_W+1)'(y); wr_rgb = COLOR_W'(rgb);
    cycle();
    wr_en = 0;
  endtask

  task automatic do_swap();
    swap_req = 1; cycle(); swap_req = 0;
    frame_done = 1; cycle(); frame_done = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    cycle(); cycle();
    checks++; if (LED_Top !== 3'd0) begin errors++; $display("FAIL rst_top: got %0d want 0", LED_Top); end
    checks++; if (LED_Bottom !== 3'd0) begin errors++; $display("FAIL rst_bot: got %0d want 0", LED_Bottom); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL rst_swap_done: got %b want 0", swap_done); end
    checks++; if (front_bank !== 1'b0) begin errors++; $display("FAIL rst_front: got %b want 0", front_bank); end
    checks++; if (busy !== CLR) begin errors++; $display("FAIL rst_busy: got %b want %b", busy, CLR); end
    reset = 0;
    if (CLR) begin
      int n = 0;
      while (busy === 1'b1 && n < 1000) begin n++; cycle(); end
      checks++; if (n != NADDR) begin errors++; $display("FAIL rst_clear_len: got %0d want %0d", n, NADDR); end
    end else begin
      cycle();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    wait_idle();
  endtask

  task automatic test_fill();
    for (int pass = 0; pass < 2; pass++) begin
      for (int y = 0; y < NROW; y++)
        for (int x = 0; x < NCOL; x++) write_px(x, y, int'($urandom_range(0, 7)));
      if (pass == 0) begin do_swap(); wait_idle(); end
    end
    for (int i = 0; i < 16; i++) begin
      rd_row = ROW_W'($urandom); rd_col = COL_W'($urandom);
      cycle();
      if (e_top_known) begin
        checks++; if (LED_Top !== e_top) begin errors++; $display("FAIL fill_top: got %0d want %0d", LED_Top, e_top); end
      end
      if (e_bot_known) begin
        checks++; if (LED_Bottom !== e_bot) begin errors++; $display("FAIL fill_bot: got %0d want %0d", LED_Bottom, e_bot); end
      end
    end
  endtask

  task automatic test_swap_basic();
    bit old_front = m_front;
    write_px(3, 2, 5);
    write_px(3, 10, 6);
    swap_req = 1; cycle(); swap_req = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swap_busy: got %b want 1", busy); end
    checks++; if (front_bank !== old_front) begin errors++; $display("FAIL swap_front_hold: got %b want %b", front_bank, old_front); end
    frame_done = 1; rd_row = 3'd2; rd_col = 5'd3; cycle(); frame_done = 0;
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL swap_done_pulse: got %b want 1", swap_done); end
    checks++; if (front_bank !== !old_front) begin errors++; $display("FAIL swap_front_toggle: got %b want %b", front_bank, !old_front); end
    if (e_top_known) begin
      checks++; if (LED_Top !== e_top) begin errors++; $display("FAIL swap_edge_old: got %0d want %0d", LED_Top, e_top); end
    end
    cycle();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_width: got %b want 0", swap_done); end
    checks++; if (LED_Top !== 3'd5) begin errors++; $display("FAIL swap_new_top: got %0d want 5", LED_Top); end
    checks++; if (LED_Bottom !== 3'd6) begin errors++; $display("FAIL swap_new_bot: got %0d want 6", LED_Bottom); end
    wait_idle();
  endtask

  task automatic test_hidden_write();
    write_px(7, 1, 3);
    rd_row = 3'd1; rd_col = 5'd7; cycle();
    if (e_top_known) begin
      checks++; if (LED_Top !== e_top) begin errors++; $display("FAIL hidden_old: got %0d want %0d", LED_Top, e_top); end
    end
    do_swap(); cycle();
    checks++; if (LED_Top !== 3'd3) begin errors++; $display("FAIL hidden_new: got %0d want 3", LED_Top); end
    wait_idle();
  endtask

  task automatic test_busy_drop();
    write_px(0, 0, 2);
    rd_row = 3'd0; rd_col = 5'd0;
    swap_req = 1; cycle(); swap_req = 0;
    write_px(0, 0, 7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", busy); end
    frame_done = 1; cycle(); frame_done = 0;
    cycle();
    checks++; if (LED_Top !== 3'd2) begin errors++; $display("FAIL drop_pixel: got %0d want 2", LED_Top); end
    wait_idle();
  endtask

  task automatic test_same_cycle();
    bit old_front = m_front;
    swap_req = 1; frame_done = 1; cycle(); idle_inputs();
    checks++; if (front_bank !== old_front) begin errors++; $display("FAIL same_front: got %b want %b", front_bank, old_front); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy); end
    cycle();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL same_no_done: got %b want 0", swap_done); end
    frame_done = 1; cycle(); frame_done = 0;
    checks++; if (front_bank !== !old_front) begin errors++; $display("FAIL same_toggle: got %b want %b", front_bank, !old_front); end
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL same_done: got %b want 1", swap_done); end
    cycle();
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL same_done_width: got %b want 0", swap_done); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    if (m_front == 0) begin do_swap(); wait_idle(); end
    swap_req = 1; cycle(); swap_req = 0;
    reset = 1; cycle(); reset = 0;
    frame_done = 1; cycle(); frame_done = 0;
    checks++; if (front_bank !== 1'b0) begin errors++; $display("FAIL rmid_front: got %b want 0", front_bank); end
    checks++; if (busy !== CLR) begin errors++; $display("FAIL rmid_busy: got %b want %b", busy, CLR); end
    for (int i = 0; i < 8; i++) begin
      if (swap_done !== 1'b0) pulses++;
      cycle();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", pulses); end
    wait_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      wr_en = 1'($urandom); wr_x = COL_W'($urandom); wr_y = (ROW_W+1)'($urandom); wr_rgb = COLOR_W'($urandom);
      swap_req = ($urandom_range(0, 19) == 0); frame_done = ($urandom_range(0, 14) == 0);
      rd_row = ROW_W'($urandom); rd_col = COL_W'($urandom);
      cycle();
      checks++; if (swap_done !== e_swap_done) begin errors++; $display("FAIL rnd_swap_done@%0d: got %b want %b", i, swap_done, e_swap_done); end
      checks++; if (front_bank !== m_front) begin errors++; $display("FAIL rnd_front@%0d: got %b want %b", i, front_bank, m_front); end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, m_busy()); end
      if (e_top_known) begin
        checks++; if (LED_Top !== e_top) begin errors++; $display("FAIL rnd_top@%0d: got %0d want %0d", i, LED_Top, e_top); end
      end
      if (e_bot_known) begin
        checks++; if (LED_Bottom !== e_bot) begin errors++; $display("FAIL rnd_bot@%0d: got %0d want %0d", i, LED_Bottom, e_bot); end
      end
    end
    wait_idle();
  endtask

  task automatic test_clear();
    int n, bad;
    reset = 1; idle_inputs(); cycle(); reset = 0;
    wait_idle();
    do_swap();
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; cycle(); end
    checks++; if (n != NADDR) begin errors++; $display("FAIL clr_swap_len: got %0d want %0d", n, NADDR); end
    bad = 0;
    for (int a = 0; a < NADDR; a++) begin
      rd_row = ROW_W'(a >> 5); rd_col = COL_W'(a); cycle();
      if (LED_Top !== 3'd0 || LED_Bottom !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_first_frame: got %0d nonzero addresses want 0", bad); end
    write_px(9, 12, 4);
    do_swap();
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; cycle(); end
    checks++; if (n != NADDR) begin errors++; $display("FAIL clr_swap2_len: got %0d want %0d", n, NADDR); end
    bad = 0;
    for (int a = 0; a < NADDR; a++) begin
      rd_row = ROW_W'(a >> 5); rd_col = COL_W'(a); cycle();
      if (LED_Top !== 3'd0) bad++;
      if (LED_Bottom !== ((a == (4 * 32 + 9)) ? 3'd4 : 3'd0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_next_frame: got %0d wrong pixels want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap_basic();
    test_hidden_write();
    test_busy_drop();
    test_same_cycle();
    test_reset_mid();
    test_random();
    if (CLR) test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
